// File: rtl/bus_frame_scheduler_pkg.sv
// Shared definitions for the serial bus frame scheduler: default widths,
// the start-bit value, the FSM state type and a frame-length helper.
package bus_frame_scheduler_pkg;

    localparam int unsigned N_DEF   = 16;
    localparam int unsigned DW_DEF  = 64;
    localparam int unsigned AW_DEF  = 4;
    localparam int unsigned CW_DEF  = 4;
    localparam int unsigned GAP_DEF = 2;

    localparam logic START_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // start bit + src addr + dst addr + data + crc
    function automatic int unsigned frame_len(input int unsigned aw,
                                              input int unsigned dw,
                                              input int unsigned cw);
        return 1 + aw + aw + dw + cw;
    endfunction

    localparam int unsigned FRAME_LEN = frame_len(AW_DEF, DW_DEF, CW_DEF);

endpackage

// File: rtl/bus_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win_idx
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt     = '0;
        win_idx = '0;
        idx     = '0;
        found   = 1'b0;
        if (enable) begin
            for (int unsigned i = 0; i < N; i++) begin
                idx = ptr + IW'(i);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    win_idx    = idx;
                    gnt[idx]   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_frame_scheduler.sv
// Shares one serial bus among N senders: round-robin pick, latch the frame,
// shift it out MSB-first, then hold the bus idle for GAP_CYCLES cycles.
module bus_frame_scheduler
    import bus_frame_scheduler_pkg::*;
#(
    parameter int unsigned N          = N_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned CW         = CW_DEF,
    parameter int unsigned GAP_CYCLES = GAP_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data_flat,
    input  logic [N*AW-1:0] dst_flat,
    input  logic [N*CW-1:0] crc_flat,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic            done,
    output logic            bus_out
);

    localparam int unsigned FL  = frame_len(AW, DW, CW);
    localparam int unsigned BCW = $clog2(FL);
    localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t         state, state_nxt;
    logic [FL-1:0]  shreg;
    logic [BCW-1:0] bit_cnt;
    logic [GCW-1:0] gap_cnt;
    logic [AW-1:0]  ptr;
    logic [AW-1:0]  win_idx;
    logic [N-1:0]   arb_gnt;
    logic           load;
    logic           last_bit;

    assign last_bit = (bit_cnt == '0);

    rr_arbiter #(
        .N  (N),
        .IW (AW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .enable  (state == ST_IDLE),
        .gnt     (arb_gnt),
        .win_idx (win_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        bus_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                busy    = 1'b1;
                bus_out = shreg[FL-1];
                done    = last_bit;
                if (last_bit) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                busy = 1'b1;
                if (gap_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame content is frozen at grant time; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grant   <= '0;
            ptr     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (load) begin
            grant   <= arb_gnt;
            ptr     <= win_idx + AW'(1);
            shreg   <= {START_BIT, win_idx,
                        dst_flat[win_idx*AW +: AW],
                        data_flat[win_idx*DW +: DW],
                        crc_flat[win_idx*CW +: CW]};
            bit_cnt <= BCW'(FL - 1);
        end else if (state == ST_SEND) begin
            shreg   <= {shreg[FL-2:0], 1'b0};
            bit_cnt <= bit_cnt - BCW'(1);
            if (last_bit) begin
                grant   <= '0;
                gap_cnt <= GCW'(GAP_CYCLES - 1);
            end
        end else if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GCW'(1);
        end
    end

endmodule

// File: tb/tb_bus_frame_scheduler.sv
// Self-checking bench: a cycle-level expectation queue built from the frame
// rules, compared every cycle, plus hand-computed directed expectations.
module tb_bus_frame_scheduler;

    localparam int unsigned N   = 16;
    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 4;
    localparam int unsigned CW  = 4;
    localparam int unsigned GAP = 2;
    localparam int unsigned FL  = 1 + AW + AW + DW + CW;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data_flat = '0;
    logic [N*AW-1:0] dst_flat = '0;
    logic [N*CW-1:0] crc_flat = '0;
    logic [N-1:0]    grant;
    logic            busy;
    logic            done;
    logic            bus_out;

    bus_frame_scheduler #(
        .N          (N),
        .DW         (DW),
        .AW         (AW),
        .CW         (CW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .data_flat (data_flat),
        .dst_flat  (dst_flat),
        .crc_flat  (crc_flat),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .bus_out   (bus_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         bus;
        logic [N-1:0] grant;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int unsigned mptr = 0;
    bit          model_on = 1'b0;
    int unsigned total = 0;
    int unsigned passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected outputs for every cycle of one frame plus its gap.
    task automatic model_start();
        int unsigned   w;
        bit            found;
        logic [FL-1:0] f;
        exp_t          e;
        w = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[(mptr + i) % N]) begin
                found = 1'b1;
                w = (mptr + i) % N;
            end
        end
        mptr = (w + 1) % N;
        f = {1'b1, AW'(w), dst_flat[w*AW +: AW], data_flat[w*DW +: DW], crc_flat[w*CW +: CW]};
        for (int k = FL - 1; k >= 0; k--) begin
            e.bus   = f[k];
            e.grant = N'(1) << w;
            e.busy  = 1'b1;
            e.done  = (k == 0);
            q.push_back(e);
        end
        for (int unsigned g = 0; g < GAP; g++) begin
            e.bus   = 1'b0;
            e.grant = '0;
            e.busy  = 1'b1;
            e.done  = 1'b0;
            q.push_back(e);
        end
    endtask

    always @(posedge clock) begin
        if (!reset_n) begin
            q.delete();
            mptr = 0;
        end else if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (req != '0) begin
            model_start();
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            if (q.size() != 0) cur = q[0];
            else begin
                cur.bus   = 1'b0;
                cur.grant = '0;
                cur.busy  = 1'b0;
                cur.done  = 1'b0;
            end
            chk("bus_out", bus_out, cur.bus);
            chk("grant",   grant,   cur.grant);
            chk("busy",    busy,    cur.busy);
            chk("done",    done,    cur.done);
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_start(output logic [N-1:0] g);
        logic [N-1:0] prev;
        bit           found;
        prev  = grant;
        found = 1'b0;
        g     = '0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock);
            if (grant != '0 && prev == '0) begin
                found = 1'b1;
                g = grant;
            end
            prev = grant;
        end
        chk("start_timeout", found, 1);
    endtask

    task automatic wait_idle();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock);
            if (!busy) found = 1'b1;
        end
        chk("idle_timeout", found, 1);
    endtask

    // Capture one frame that starts on the next edge; returns the bits and done cycle.
    task automatic capture(output logic [FL-1:0] cap, output int unsigned dcyc, input bit mid_change);
        cap  = '0;
        dcyc = 0;
        for (int unsigned c = 1; c <= FL; c++) begin
            @(negedge clock);
            cap[FL - c] = bus_out;
            if (done && dcyc == 0) dcyc = c;
            if (c == 1) begin
                chk("first_grant", grant, 16'h0001);
                if (mid_change) begin
                    data_flat[0 +: DW] = 64'hFFFF_FFFF_FFFF_FFFF;
                    req = '0;
                end
            end
            if (c == FL) req = '0;
        end
    endtask

    logic [FL-1:0] cap;
    int unsigned   dcyc;
    logic [N-1:0]  g;

    initial begin
        repeat (3) @(negedge clock);
        model_on = 1'b1;
        chk("reset_state", {bus_out, busy, done, grant}, '0);
        reset_n = 1'b1;

        // single request from sender 0
        data_flat[0 +: DW] = 64'h1;
        dst_flat[0 +: AW]  = 4'h1;
        crc_flat[0 +: CW]  = 4'h1;
        req = 16'h0001;
        capture(cap, dcyc, 1'b0);
        chk("frame1", cap, {1'b1, 4'h0, 4'h1, 64'h1, 4'h1});
        chk("done1_cycle", dcyc, 77);
        @(negedge clock); chk("gap_busy_78", busy, 1);
        @(negedge clock); chk("gap_busy_79", busy, 1);
        @(negedge clock); chk("idle_busy_80", busy, 0);

        // contention between senders 0 and 1
        do_reset();
        data_flat[DW +: DW] = 64'hDEAD_BEEF_0BAD_F00D;
        dst_flat[AW +: AW]  = 4'h7;
        crc_flat[CW +: CW]  = 4'h3;
        req = 16'h0003;
        wait_start(g); chk("cont_g0", g, 16'h0001);
        wait_start(g); chk("cont_g1", g, 16'h0002);
        wait_start(g); chk("cont_g2", g, 16'h0001);
        req = '0;
        wait_idle();

        // pointer wrap from sender 15
        do_reset();
        data_flat[15*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        dst_flat[15*AW +: AW]  = 4'h2;
        crc_flat[15*CW +: CW]  = 4'hE;
        req = 16'h8000;
        wait_start(g); chk("wrap_g0", g, 16'h8000);
        req = 16'h8001;
        wait_start(g); chk("wrap_g1", g, 16'h0001);
        wait_start(g); chk("wrap_g2", g, 16'h8000);
        req = '0;
        wait_idle();

        // inputs change after the start bit
        do_reset();
        data_flat[0 +: DW] = 64'hA5A5_0000_1234_5678;
        dst_flat[0 +: AW]  = 4'h9;
        crc_flat[0 +: CW]  = 4'hC;
        req = 16'h0001;
        capture(cap, dcyc, 1'b1);
        chk("frame_mid", cap, {1'b1, 4'h0, 4'h9, 64'hA5A5_0000_1234_5678, 4'hC});
        chk("done_mid_cycle", dcyc, 77);
        wait_idle();

        // reset in the middle of a frame
        do_reset();
        req = 16'h0001;
        wait_start(g); chk("rst_g0", g, 16'h0001);
        repeat (29) @(negedge clock);
        reset_n = 1'b0;
        req = '0;
        @(negedge clock);
        chk("rst_abort", {bus_out, busy, done, grant}, '0);
        reset_n = 1'b1;
        req = 16'h0006;
        wait_start(g); chk("rst_after", g, 16'h0002);
        req = '0;
        wait_idle();

        // long idle
        do_reset();
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            chk("idle_quiet", {bus_out, busy, done, grant}, '0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
